// File: rtl/ram_16x8_pkg.sv
// Shared sizes and loader state encoding for the 16x8 program RAM.
package ram_16x8_pkg;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/ram_loader_fsm.sv
// Loader FSM: streams prog_data bytes into consecutive words from 0.
module ram_loader_fsm
  import ram_16x8_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode_i,
  input  logic              prog_valid_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              prog_ready_o,
  output logic              prog_done_o,
  output logic              idle_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (prog_mode_i) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (prog_valid_i) begin
          we_o = 1'b1;
          // Pointer parks on the last word instead of wrapping
          if (ptr_q == LAST) state_d = DONE;
          else               ptr_d   = ptr_q + 1'b1;
        end
        if (!prog_mode_i) state_d = IDLE;
      end
      DONE: begin
        if (!prog_mode_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign waddr_o      = ptr_q;
  assign prog_ready_o = (state_q == LOAD);
  assign prog_done_o  = (state_q == DONE);
  assign idle_o       = (state_q == IDLE);

endmodule

// File: rtl/ram_16x8.sv
// 16x8 RAM with run-mode read/write port and a byte-stream loader.
module ram_16x8
  import ram_16x8_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_bar,
  input  logic              output_bar,
  input  logic              prog_mode,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;

  logic              ld_we, ld_idle;
  logic [ADDR_W-1:0] ld_addr;
  logic              run_en, run_we, run_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  ram_loader_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .prog_mode_i  (prog_mode),
    .prog_valid_i (prog_valid),
    .we_o         (ld_we),
    .waddr_o      (ld_addr),
    .prog_ready_o (prog_ready),
    .prog_done_o  (prog_done),
    .idle_o       (ld_idle)
  );

  assign run_en = ld_idle & ~prog_mode;
  assign run_we = run_en & ~write_bar;
  assign run_rd = run_en & ~output_bar;

  // Single write port: loader owns it whenever the FSM is active
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address_in;
    mem_wdata = data_in;
    if (!ld_idle) begin
      mem_we    = ld_we & ~rst;
      mem_addr  = ld_addr;
      mem_wdata = prog_data;
    end else begin
      mem_we    = run_we & ~rst;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  always_comb begin
    dv_d   = run_rd;
    dout_d = dout_q;
    if (run_rd) dout_d = mem_q[address_in];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dv_q   <= dv_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;

endmodule

// File: tb/tb_ram_16x8.sv
// Bench for ram_16x8: directed sequences, vector table, random vs model.
module tb_ram_16x8;
  import ram_16x8_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] address_in;
  logic [7:0] data_in;
  logic       write_bar, output_bar;
  logic       prog_mode, prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready, prog_done, data_valid;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  ram_16x8 dut (
    .clk        (clk),
    .rst        (rst),
    .address_in (address_in),
    .data_in    (data_in),
    .write_bar  (write_bar),
    .output_bar (output_bar),
    .prog_mode  (prog_mode),
    .prog_data  (prog_data),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_DONE = 2;

  logic [7:0] mdl [16];
  int         phase = P_IDLE;
  int         cnt   = 0;
  logic [7:0] e_do  = 8'h00;
  logic       e_dv  = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    logic       wb;
    logic       ob;
    logic [7:0] edo;
    logic       edv;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: what one clock edge does, from the block's rules
  function automatic void model_edge();
    bit run;
    if (rst) begin
      phase = P_IDLE;
      cnt   = 0;
      e_do  = 8'h00;
      e_dv  = 1'b0;
      return;
    end
    run  = !prog_mode && phase == P_IDLE;
    e_dv = run && !output_bar;
    if (e_dv) e_do = mdl[address_in];
    if (run && !write_bar) mdl[address_in] = data_in;
    case (phase)
      P_IDLE: if (prog_mode) begin phase = P_LOAD; cnt = 0; end
      P_LOAD: begin
        if (prog_valid) begin
          mdl[cnt] = prog_data;
          cnt++;
          if (cnt == 16) phase = P_DONE;
        end
        if (!prog_mode) phase = P_IDLE;
      end
      default: if (!prog_mode) phase = P_IDLE;
    endcase
  endfunction

  task automatic drive(logic r, logic [3:0] a, logic [7:0] d,
                       logic wb, logic ob, logic pm,
                       logic [7:0] pd, logic pv);
    rst        = r;
    address_in = a;
    data_in    = d;
    write_bar  = wb;
    output_bar = ob;
    prog_mode  = pm;
    prog_data  = pd;
    prog_valid = pv;
  endtask

  task automatic step(bit chkm);
    model_edge();
    @(posedge clk);
    #1;
    if (chkm) begin
      chk("data_out", data_out, e_do);
      chk("data_valid", {7'b0, data_valid}, {7'b0, e_dv});
      chk("prog_ready", {7'b0, prog_ready}, {7'b0, phase == P_LOAD});
      chk("prog_done", {7'b0, prog_done}, {7'b0, phase == P_DONE});
    end
  endtask

  task automatic rd(logic [3:0] a);
    drive(0, a, 8'h00, 1, 0, 0, 8'h00, 0);
    step(1);
  endtask

  initial begin
    logic pm_r;
    tbl[0] = '{4'd7,  8'hA5, 1'b0, 1'b1, 8'h1F, 1'b0};
    tbl[1] = '{4'd7,  8'h00, 1'b1, 1'b0, 8'hA5, 1'b1};
    tbl[2] = '{4'd3,  8'h11, 1'b0, 1'b1, 8'hA5, 1'b0};
    tbl[3] = '{4'd3,  8'h22, 1'b0, 1'b0, 8'h11, 1'b1};
    tbl[4] = '{4'd3,  8'h00, 1'b1, 1'b0, 8'h22, 1'b1};
    tbl[5] = '{4'd0,  8'h00, 1'b1, 1'b1, 8'h22, 1'b0};
    tbl[6] = '{4'd0,  8'h00, 1'b1, 1'b0, 8'h10, 1'b1};
    tbl[7] = '{4'd15, 8'h00, 1'b1, 1'b0, 8'h1F, 1'b1};

    drive(1, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    step(0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_valid", {7'b0, data_valid}, 8'h00);
    chk("rst_prog_ready", {7'b0, prog_ready}, 8'h00);
    chk("rst_prog_done", {7'b0, prog_done}, 8'h00);

    // Full load of 10..1F with prog_valid held high
    drive(0, 0, 0, 1, 1, 1, 8'hFF, 1);
    step(1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 1, 1, 8'(8'h10 + i), 1);
      step(1);
      if (i == 14) chk("load_not_done_yet", {7'b0, prog_done}, 8'h00);
      if (i == 15) chk("load_done", {7'b0, prog_done}, 8'h01);
    end
    drive(0, 0, 0, 1, 1, 1, 8'hEE, 1);
    step(1);
    chk("done_holds", {7'b0, prog_done}, 8'h01);
    drive(0, 0, 0, 1, 1, 0, 8'h00, 0);
    step(1);
    chk("done_clears", {7'b0, prog_done}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("load_read", data_out, 8'(8'h10 + i));
    end

    for (int i = 0; i < 8; i++) begin
      drive(0, tbl[i].a, tbl[i].d, tbl[i].wb, tbl[i].ob, 0, 8'h00, 0);
      step(0);
      chk($sformatf("vec%0d_dout", i), data_out, tbl[i].edo);
      chk($sformatf("vec%0d_dv", i), {7'b0, data_valid},
          {7'b0, tbl[i].edv});
    end

    // Abort after 5 bytes, then re-enter and load one byte
    drive(0, 0, 0, 1, 1, 1, 8'h00, 0);
    step(1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 1, 1, 8'(8'hC0 + i), 1);
      step(1);
    end
    drive(0, 0, 0, 1, 1, 0, 8'h00, 0);
    step(1);
    chk("abort_ready", {7'b0, prog_ready}, 8'h00);
    for (int i = 0; i < 16; i++) rd(4'(i));
    rd(4'd6);
    chk("abort_kept6", data_out, 8'h16);
    drive(0, 0, 0, 1, 1, 1, 8'h00, 0);
    step(1);
    drive(0, 0, 0, 1, 1, 1, 8'hEE, 1);
    step(1);
    drive(0, 0, 0, 1, 1, 0, 8'h00, 0);
    step(1);
    rd(4'd0);
    chk("reentry_addr0", data_out, 8'hEE);
    rd(4'd1);
    chk("reentry_addr1", data_out, 8'hC1);

    // Reset mid-load; run port toggled while loading
    drive(0, 0, 0, 1, 1, 1, 8'h00, 0);
    step(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1, 1, 8'(8'hD0 + i), 1);
      step(1);
    end
    drive(0, 4'd9, 8'h99, 0, 0, 1, 8'h00, 0);
    step(1);
    chk("prog_run_dv", {7'b0, data_valid}, 8'h00);
    drive(1, 4'd9, 8'h99, 0, 0, 1, 8'h55, 1);
    step(1);
    chk("midrst_ready", {7'b0, prog_ready}, 8'h00);
    chk("midrst_dout", data_out, 8'h00);
    for (int i = 0; i < 3; i++) begin
      rd(4'(i));
      chk("midrst_kept", data_out, 8'(8'hD0 + i));
    end
    rd(4'd3);
    chk("midrst_no_write", data_out, 8'hC3);
    rd(4'd9);
    chk("prog_no_run_write", data_out, 8'h19);

    pm_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39) == 0) pm_r = ~pm_r;
      drive(1'($urandom_range(63) == 0), 4'($urandom), 8'($urandom),
            1'($urandom_range(1)), 1'($urandom_range(1)), pm_r,
            8'($urandom), pm_r & 1'($urandom_range(1)));
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
